// File: rtl/autoconfig_master_if.sv
// autoconfig_master_if: request/acknowledge bus between the AutoConfig scan
// engine (master) and the Zorro configuration-slot access logic (slave).
interface autoconfig_master_if;
  logic       ZREQ;    // transaction request
  logic       ZRW;     // 1 = read, 0 = write
  logic [7:0] ZOFS;    // byte offset inside 0xE80000
  logic [3:0] ZWDATA;  // write nibble (bus D[15:12])
  logic [3:0] ZRDATA;  // read nibble
  logic       ZACK;    // transaction complete

  modport master (output ZREQ, ZRW, ZOFS, ZWDATA, input ZRDATA, ZACK);
  modport slave  (input ZREQ, ZRW, ZOFS, ZWDATA, output ZRDATA, ZACK);
endinterface

// File: rtl/autoconfig_master.sv
// autoconfig_master: walks the boards presented at the 0xE80000 AutoConfig
// slot, sizes each one, places it in the memory or I/O pool and either
// commits a base address or shuts it up. Reports each board on CFG_*.
// Optional feature: define AC_TIMEOUT_EN to abort a bus request that sees no
// ZACK within 255 cycles (ERR=1); otherwise requests wait forever, ERR=0.
module autoconfig_master (
  input  logic                CLKCPU,
  input  logic                RESET,
  input  logic                START,
  autoconfig_master_if.master zbus,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  output logic [3:0]          NBOARDS,
  output logic                CFG_STB,
  output logic [7:0]          CFG_BASE,
  output logic                CFG_SHUT
);
  typedef enum logic [3:0] {
    IDLE, RD_HI, RD_LO, ALLOC, WR_LO, WR_HI, SHUTUP, NEXT, FINISH
  } state_t;

  localparam logic [7:0] OFS_TYPE_HI = 8'h00;
  localparam logic [7:0] OFS_TYPE_LO = 8'h02;
  localparam logic [7:0] OFS_BASE_HI = 8'h48;
  localparam logic [7:0] OFS_BASE_LO = 8'h4A;
  localparam logic [7:0] OFS_SHUTUP  = 8'h4C;
  localparam logic [7:0] MEM_START   = 8'h20;
  localparam logic [7:0] IO_START    = 8'hE9;
  localparam logic [8:0] MEM_LIMIT   = 9'h0A0;
  localparam logic [8:0] IO_LIMIT    = 9'h0F0;

  state_t     state_q, state_d;
  logic       zreq_q, zreq_d, zrw_q, zrw_d;
  logic [7:0] zofs_q, zofs_d;
  logic [3:0] zwdata_q, zwdata_d;
  // Only type[7:5] (class, pool) and type[2:0] (size) matter; bits 4:3 are dropped.
  logic [2:0] type_cls_q, type_cls_d, type_size_q, type_size_d;
  logic [7:0] base_q, base_d, mem_ptr_q, mem_ptr_d, io_ptr_q, io_ptr_d;
  logic       shut_q, shut_d, busy_q, busy_d, done_q, done_d;
  logic [3:0] nboards_q, nboards_d;
  logic       cfg_stb_q, cfg_stb_d, cfg_shut_q, cfg_shut_d;
  logic [7:0] cfg_base_q, cfg_base_d;
`ifdef AC_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`endif

  logic       req_active, req_rw, bus_done;
  logic [7:0] req_ofs;
  logic [3:0] req_wdata;
  logic [8:0] size9, ptr9, limit9, base9, end9;
  logic       fit;

  // Placement of the current board: 9-bit round-up of the pool pointer to its size.
  always_comb begin
    case (type_size_q)
      3'd0:    size9 = 9'd128;
      3'd1:    size9 = 9'd1;
      3'd2:    size9 = 9'd2;
      3'd3:    size9 = 9'd4;
      3'd4:    size9 = 9'd8;
      3'd5:    size9 = 9'd16;
      3'd6:    size9 = 9'd32;
      default: size9 = 9'd64;
    endcase
    ptr9   = type_cls_q[0] ? {1'b0, mem_ptr_q} : {1'b0, io_ptr_q};
    limit9 = type_cls_q[0] ? MEM_LIMIT : IO_LIMIT;
    base9  = (ptr9 + size9 - 9'd1) & ~(size9 - 9'd1);
    // An 8MB board only goes at 0x20, and only into an untouched memory pool.
    if (type_size_q == 3'd0) begin
      base9 = {1'b0, MEM_START};
    end
    end9 = base9 + size9;
    fit  = (end9 <= limit9) &&
           ((type_size_q != 3'd0) || (type_cls_q[0] && (mem_ptr_q == MEM_START)));
  end

  // Next-state and next-output logic for the scan FSM and its bus handshake.
  always_comb begin
    state_d     = state_q;
    zreq_d      = zreq_q;
    zrw_d       = zrw_q;
    zofs_d      = zofs_q;
    zwdata_d    = zwdata_q;
    type_cls_d  = type_cls_q;
    type_size_d = type_size_q;
    base_d      = base_q;
    mem_ptr_d   = mem_ptr_q;
    io_ptr_d    = io_ptr_q;
    shut_d      = shut_q;
    done_d      = done_q;
    nboards_d   = nboards_q;
    cfg_stb_d   = 1'b0;
    cfg_base_d  = cfg_base_q;
    cfg_shut_d  = cfg_shut_q;
`ifdef AC_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = err_q;
`endif
    req_active  = 1'b0;
    req_rw      = 1'b0;
    req_ofs     = 8'h00;
    req_wdata   = 4'h0;
    bus_done    = 1'b0;

    case (state_q)
      RD_HI:  begin req_active = 1'b1; req_rw = 1'b1; req_ofs = OFS_TYPE_HI; end
      RD_LO:  begin req_active = 1'b1; req_rw = 1'b1; req_ofs = OFS_TYPE_LO; end
      WR_LO:  begin req_active = 1'b1; req_ofs = OFS_BASE_LO; req_wdata = base_q[3:0]; end
      WR_HI:  begin req_active = 1'b1; req_ofs = OFS_BASE_HI; req_wdata = base_q[7:4]; end
      SHUTUP: begin req_active = 1'b1; req_ofs = OFS_SHUTUP; end
      default: ;
    endcase

    // Each bus state enters with ZREQ low, so the cycle after an ACK is always idle.
    if (req_active) begin
      if (!zreq_q) begin
        zreq_d   = 1'b1;
        zrw_d    = req_rw;
        zofs_d   = req_ofs;
        zwdata_d = req_wdata;
`ifdef AC_TIMEOUT_EN
        tmo_d    = 8'd0;
`endif
      end else if (zbus.ZACK) begin
        zreq_d   = 1'b0;
        bus_done = 1'b1;
`ifdef AC_TIMEOUT_EN
      end else if (tmo_q == 8'd254) begin
        zreq_d   = 1'b0;
        err_d    = 1'b1;
        state_d  = FINISH;
      end else begin
        tmo_d    = tmo_q + 8'd1;
`endif
      end
    end

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = RD_HI;
          done_d    = 1'b0;
          nboards_d = 4'd0;
          mem_ptr_d = MEM_START;
          io_ptr_d  = IO_START;
`ifdef AC_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      RD_HI: if (bus_done) begin
        type_cls_d = zbus.ZRDATA[3:1];
        state_d    = RD_LO;
      end
      RD_LO: if (bus_done) begin
        type_size_d = zbus.ZRDATA[2:0];
        state_d     = ALLOC;
      end
      ALLOC: begin
        if (type_cls_q[2:1] != 2'b11) begin
          state_d = FINISH;
        end else if (fit) begin
          base_d  = base9[7:0];
          shut_d  = 1'b0;
          state_d = WR_LO;
          if (type_cls_q[0]) mem_ptr_d = end9[7:0];
          else               io_ptr_d  = end9[7:0];
        end else begin
          base_d  = 8'h00;
          shut_d  = 1'b1;
          state_d = SHUTUP;
        end
      end
      WR_LO:  if (bus_done) state_d = WR_HI;
      WR_HI:  if (bus_done) state_d = NEXT;
      SHUTUP: if (bus_done) state_d = NEXT;
      NEXT: begin
        cfg_stb_d  = 1'b1;
        cfg_base_d = base_q;
        cfg_shut_d = shut_q;
        nboards_d  = nboards_q + 4'd1;
        state_d    = (nboards_q == 4'd7) ? FINISH : RD_HI;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops the bus request immediately.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      zreq_q      <= 1'b0;
      zrw_q       <= 1'b0;
      zofs_q      <= 8'h00;
      zwdata_q    <= 4'h0;
      type_cls_q  <= 3'd0;
      type_size_q <= 3'd0;
      base_q      <= 8'h00;
      mem_ptr_q   <= MEM_START;
      io_ptr_q    <= IO_START;
      shut_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nboards_q   <= 4'd0;
      cfg_stb_q   <= 1'b0;
      cfg_base_q  <= 8'h00;
      cfg_shut_q  <= 1'b0;
`ifdef AC_TIMEOUT_EN
      tmo_q       <= 8'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      zreq_q      <= zreq_d;
      zrw_q       <= zrw_d;
      zofs_q      <= zofs_d;
      zwdata_q    <= zwdata_d;
      type_cls_q  <= type_cls_d;
      type_size_q <= type_size_d;
      base_q      <= base_d;
      mem_ptr_q   <= mem_ptr_d;
      io_ptr_q    <= io_ptr_d;
      shut_q      <= shut_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      nboards_q   <= nboards_d;
      cfg_stb_q   <= cfg_stb_d;
      cfg_base_q  <= cfg_base_d;
      cfg_shut_q  <= cfg_shut_d;
`ifdef AC_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign zbus.ZREQ   = zreq_q;
  assign zbus.ZRW    = zrw_q;
  assign zbus.ZOFS   = zofs_q;
  assign zbus.ZWDATA = zwdata_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign NBOARDS     = nboards_q;
  assign CFG_STB     = cfg_stb_q;
  assign CFG_BASE    = cfg_base_q;
  assign CFG_SHUT    = cfg_shut_q;
`ifdef AC_TIMEOUT_EN
  assign ERR         = err_q;
`else
  assign ERR         = 1'b0;
`endif
endmodule

// File: tb/tb_autoconfig_master.sv
// tb_autoconfig_master: board-chain slave model plus a placement reference
// model; table vectors, randomized board chains, reset and timeout sequences.
module tb_autoconfig_master;
  logic       CLKCPU = 1'b0;
  logic       RESET, START;
  logic       BUSY, DONE, ERR, CFG_STB, CFG_SHUT;
  logic [3:0] NBOARDS;
  logic [7:0] CFG_BASE;

  autoconfig_master_if zbus();

  autoconfig_master dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .START(START), .zbus(zbus),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .NBOARDS(NBOARDS),
    .CFG_STB(CFG_STB), .CFG_BASE(CFG_BASE), .CFG_SHUT(CFG_SHUT)
  );

  always #5 CLKCPU = ~CLKCPU;

  typedef struct packed { logic rw; logic [7:0] ofs; logic [3:0] data; } bus_t;
  typedef struct packed { logic [7:0] base; logic shut; } cfg_t;
  typedef struct packed {
    logic [71:0] types;
    logic [7:0]  nt;
    logic [7:0]  exp_n;
    logic [7:0]  exp_base0;
    logic [7:0]  exp_base_last;
    logic        exp_shut_last;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  logic [7:0] boards[$];
  int   board_idx = 0;
  bus_t bus_log[$], exp_bus[$];
  cfg_t cfg_log[$], exp_cfg[$];
  int   exp_n;
  bit   hold_all = 0, hold_48 = 0, in_req = 0;
  int   wait_cnt = 0, proto_errs = 0, req_count = 0;
  logic [12:0] snap;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cur_type();
    return (board_idx < boards.size()) ? boards[board_idx] : 8'h0F;
  endfunction

  // Slave: acks after 0..3 cycles, serves type nibbles, logs traffic, checks handshake rules.
  initial begin
    bus_t b;
    logic [7:0] t;
    zbus.ZACK = 1'b0;
    zbus.ZRDATA = 4'h0;
    forever begin
      @(negedge CLKCPU);
      if (RESET) begin
        zbus.ZACK = 1'b0;
        in_req = 0;
      end else if (zbus.ZACK) begin
        zbus.ZACK = 1'b0;
        in_req = 0;
        if (zbus.ZREQ) proto_errs++;
      end else if (!zbus.ZREQ) begin
        in_req = 0;
      end else begin
        if (!in_req) begin
          in_req = 1;
          snap = {zbus.ZRW, zbus.ZOFS, zbus.ZWDATA};
          req_count++;
          wait_cnt = $urandom_range(0, 3);
        end else if (snap != {zbus.ZRW, zbus.ZOFS, zbus.ZWDATA}) begin
          proto_errs++;
        end
        if (!(hold_all || (hold_48 && zbus.ZOFS == 8'h48))) begin
          if (wait_cnt == 0) begin
            zbus.ZACK = 1'b1;
            t = cur_type();
            b.rw = zbus.ZRW;
            b.ofs = zbus.ZOFS;
            if (zbus.ZRW) begin
              zbus.ZRDATA = (zbus.ZOFS == 8'h00) ? t[7:4] :
                            (zbus.ZOFS == 8'h02) ? t[3:0] : 4'hF;
              b.data = zbus.ZRDATA;
            end else begin
              b.data = zbus.ZWDATA;
              if (zbus.ZOFS == 8'h48 || zbus.ZOFS == 8'h4C) board_idx++;
            end
            bus_log.push_back(b);
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // Report monitor.
  initial forever begin
    cfg_t c;
    @(negedge CLKCPU);
    if (CFG_STB) begin
      c.base = CFG_BASE;
      c.shut = CFG_SHUT;
      cfg_log.push_back(c);
    end
  end

  // Reference: expected bus traffic and reports for the board chain in 'boards'.
  function automatic void model_scan();
    int mem = 'h20, io = 'hE9, n = 0, size, ptr, lim, base, code;
    bit fit;
    bus_t b;
    cfg_t c;
    logic [7:0] t;
    exp_bus.delete();
    exp_cfg.delete();
    forever begin
      t = (n < boards.size()) ? boards[n] : 8'h0F;
      b.rw = 1; b.ofs = 8'h00; b.data = t[7:4]; exp_bus.push_back(b);
      b.ofs = 8'h02; b.data = t[3:0]; exp_bus.push_back(b);
      if (t[7:6] != 2'b11) break;
      code = int'(t[2:0]);
      size = (code == 0) ? 128 : (1 << (code - 1));
      ptr  = t[5] ? mem : io;
      lim  = t[5] ? 'hA0 : 'hF0;
      if (size == 128) begin
        base = 'h20;
        fit  = t[5] && (mem == 'h20);
      end else begin
        base = ((ptr + size - 1) / size) * size;
        fit  = (base + size) <= lim;
      end
      b.rw = 0;
      if (fit) begin
        if (t[5]) mem = base + size; else io = base + size;
        b.ofs = 8'h4A; b.data = 4'(base % 16); exp_bus.push_back(b);
        b.ofs = 8'h48; b.data = 4'(base / 16); exp_bus.push_back(b);
        c.base = 8'(base); c.shut = 0;
      end else begin
        b.ofs = 8'h4C; b.data = 4'h0; exp_bus.push_back(b);
        c.base = 8'h00; c.shut = 1;
      end
      exp_cfg.push_back(c);
      n++;
      if (n == 8) break;
    end
    exp_n = n;
  endfunction

  // One full scan of 'boards', compared against the reference model.
  task automatic run_scan(input string tag, input bit extra_start);
    int cyc;
    board_idx = 0;
    bus_log.delete();
    cfg_log.delete();
    proto_errs = 0;
    model_scan();
    @(negedge CLKCPU); START = 1'b1;
    @(negedge CLKCPU); START = 1'b0;
    chk({tag, " busy_after_start"}, int'(BUSY), 1);
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLKCPU);
      if (extra_start && cyc == 4) START = 1'b1;
      if (cyc == 5) START = 1'b0;
      if (DONE) break;
    end
    START = 1'b0;
    chk({tag, " done"}, int'(DONE), 1);
    chk({tag, " busy_end"}, int'(BUSY), 0);
    chk({tag, " err"}, int'(ERR), 0);
    chk({tag, " nboards"}, int'(NBOARDS), exp_n);
    chk({tag, " handshake"}, proto_errs, 0);
    chk({tag, " bus_count"}, bus_log.size(), exp_bus.size());
    chk({tag, " cfg_count"}, cfg_log.size(), exp_cfg.size());
    for (int i = 0; i < exp_bus.size() && i < bus_log.size(); i++)
      chk($sformatf("%s bus[%0d]", tag, i), int'(bus_log[i]), int'(exp_bus[i]));
    for (int i = 0; i < exp_cfg.size() && i < cfg_log.size(); i++)
      chk($sformatf("%s cfg[%0d]", tag, i), int'(cfg_log[i]), int'(exp_cfg[i]));
    $display("scan %s: boards=%0d nboards=%0d bus=%0d cfg=%0d", tag, boards.size(),
             NBOARDS, bus_log.size(), cfg_log.size());
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   found, rc, cnt;
    logic [7:0] t;

    vecs[0] = '{types: 72'hE5,       nt: 1, exp_n: 1, exp_base0: 8'h20, exp_base_last: 8'h20, exp_shut_last: 0};
    vecs[1] = '{types: 72'hE6E1,     nt: 2, exp_n: 2, exp_base0: 8'h20, exp_base_last: 8'h40, exp_shut_last: 0};
    vecs[2] = '{types: {9{8'hC1}},   nt: 8, exp_n: 8, exp_base0: 8'hE9, exp_base_last: 8'h00, exp_shut_last: 1};
    vecs[3] = '{types: 72'hE0E1,     nt: 2, exp_n: 2, exp_base0: 8'h20, exp_base_last: 8'h00, exp_shut_last: 1};
    vecs[4] = '{types: 72'h0F,       nt: 1, exp_n: 0, exp_base0: 8'h00, exp_base_last: 8'h00, exp_shut_last: 0};
    vecs[5] = '{types: 72'hE7E7E7,   nt: 3, exp_n: 3, exp_base0: 8'h40, exp_base_last: 8'h00, exp_shut_last: 1};
    vecs[6] = '{types: 72'hE1E0,     nt: 2, exp_n: 2, exp_base0: 8'h20, exp_base_last: 8'h00, exp_shut_last: 1};
    vecs[7] = '{types: {9{8'hC1}},   nt: 9, exp_n: 8, exp_base0: 8'hE9, exp_base_last: 8'h00, exp_shut_last: 1};

    RESET = 1'b1;
    START = 1'b0;
    repeat (3) @(negedge CLKCPU);
    chk("reset ZREQ", int'(zbus.ZREQ), 0);
    chk("reset BUSY", int'(BUSY), 0);
    chk("reset DONE", int'(DONE), 0);
    chk("reset NBOARDS", int'(NBOARDS), 0);
    chk("reset CFG_STB", int'(CFG_STB), 0);
    chk("reset CFG_BASE", int'(CFG_BASE), 0);
    chk("reset ERR", int'(ERR), 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLKCPU);

    for (int v = 0; v < 8; v++) begin
      boards.delete();
      for (int i = 0; i < int'(vecs[v].nt); i++) boards.push_back(vecs[v].types[8*i +: 8]);
      run_scan($sformatf("vec%0d", v), v == 1);
      chk($sformatf("vec%0d table_nboards", v), int'(NBOARDS), int'(vecs[v].exp_n));
      if (vecs[v].exp_n != 0 && cfg_log.size() != 0) begin
        chk($sformatf("vec%0d table_base0", v), int'(cfg_log[0].base), int'(vecs[v].exp_base0));
        chk($sformatf("vec%0d table_base_last", v), int'(cfg_log[$].base), int'(vecs[v].exp_base_last));
        chk($sformatf("vec%0d table_shut_last", v), int'(cfg_log[$].shut), int'(vecs[v].exp_shut_last));
      end
    end

    // Reset while the commit write (0x48) is pending.
    boards = {8'hE5};
    board_idx = 0;
    hold_48 = 1;
    @(negedge CLKCPU); START = 1'b1;
    @(negedge CLKCPU); START = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge CLKCPU);
      if (zbus.ZREQ && zbus.ZOFS == 8'h48) begin found = 1; break; end
    end
    chk("rst reach_wr_hi", found, 1);
    #2 RESET = 1'b1;
    #1;
    chk("rst ZREQ", int'(zbus.ZREQ), 0);
    chk("rst ZRW", int'(zbus.ZRW), 0);
    chk("rst ZOFS", int'(zbus.ZOFS), 0);
    chk("rst ZWDATA", int'(zbus.ZWDATA), 0);
    chk("rst BUSY", int'(BUSY), 0);
    chk("rst DONE", int'(DONE), 0);
    chk("rst NBOARDS", int'(NBOARDS), 0);
    chk("rst CFG_BASE", int'(CFG_BASE), 0);
    chk("rst CFG_SHUT", int'(CFG_SHUT), 0);
    chk("rst CFG_STB", int'(CFG_STB), 0);
    chk("rst ERR", int'(ERR), 0);
    hold_48 = 0;
    repeat (3) @(negedge CLKCPU);
    RESET = 1'b0;
    rc = req_count;
    repeat (30) @(negedge CLKCPU);
    chk("rst no_request_after", req_count, rc);
    chk("rst idle_after", int'(BUSY), 0);
    $display("reset mid WR_HI: requests_after=%0d", req_count - rc);

`ifdef AC_TIMEOUT_EN
    // No ACK at all: the type read must be abandoned after 255 cycles.
    boards.delete();
    hold_all = 1;
    @(negedge CLKCPU); START = 1'b1;
    @(negedge CLKCPU); START = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge CLKCPU);
      if (zbus.ZREQ) cnt++;
      else if (cnt > 0) break;
    end
    for (int cyc = 0; cyc < 10 && !DONE; cyc++) @(negedge CLKCPU);
    chk("tmo zreq_cycles", cnt, 255);
    chk("tmo ERR", int'(ERR), 1);
    chk("tmo DONE", int'(DONE), 1);
    chk("tmo NBOARDS", int'(NBOARDS), 0);
    hold_all = 0;
    $display("timeout: zreq_high_cycles=%0d err=%0d", cnt, ERR);
`else
    cnt = 0;
`endif

    // Randomized board chains.
    for (int r = 0; r < 24; r++) begin
      boards.delete();
      for (int i = 0; i < int'($urandom_range(0, 9)); i++) begin
        t = 8'($urandom);
        if ($urandom_range(0, 7) != 0) t[7:6] = 2'b11;
        if (!t[5] && t[2:0] == 3'd0) t[2:0] = 3'd1;
        boards.push_back(t);
      end
      run_scan($sformatf("rand%0d", r), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/autoconfig_master.md
AUTOCONFIG_MASTER -- requirements
Module: autoconfig_master

Interface
REQ-001 SHALL have port CLKCPU, input, 1, single clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET, input, 1, asynchronous, active-high.
REQ-003 SHALL have port START, input, 1, one-cycle pulse that begins a scan of the 0xE80000 config slot.
REQ-004 SHALL have port ZREQ, output, 1, bus transaction request.
REQ-005 SHALL have port ZRW, output, 1, 1=read, 0=write.
REQ-006 SHALL have port ZOFS, output, 8, byte offset within 0xE80000.
REQ-007 SHALL have port ZWDATA, output, 4, write nibble (bus D[15:12]).
REQ-008 SHALL have port ZRDATA, input, 4, read nibble.
REQ-009 SHALL have port ZACK, input, 1, transaction complete.
REQ-010 SHALL have ports BUSY, DONE and ERR, output, 1 each: scan running, scan finished, timeout abort.
REQ-011 SHALL have port NBOARDS, output, 4, boards handled (configured plus shut up).
REQ-012 SHALL have ports CFG_STB (1-cycle pulse), CFG_BASE (8, A[23:16]) and CFG_SHUT (1), all outputs, reporting each board result.

Function
REQ-013 Handshake SHALL hold ZREQ, ZRW, ZOFS and ZWDATA stable until ZACK=1 is sampled, drop ZREQ the next cycle, and keep at least one idle cycle between requests; ZRDATA SHALL be captured on the ZACK cycle.
REQ-014 States SHALL be IDLE, RD_HI, RD_LO, ALLOC, WR_LO, WR_HI, SHUTUP, NEXT, FINISH.
REQ-015 IDLE+START SHALL go to RD_HI; START SHALL be ignored while BUSY=1.
REQ-016 RD_HI SHALL read offset 0x00 into type[7:4]; RD_LO SHALL read offset 0x02 into type[3:0]; nibbles SHALL be taken uninverted.
REQ-017 ALLOC SHALL go to FINISH with no board counted when type[7:6]!=2'b11.
REQ-018 Size SHALL decode from type[2:0] in 64K units: 000=128, 001=1, 010=2, 011=4, 100=8, 101=16, 110=32, 111=64.
REQ-019 type[5]=1 SHALL allocate from the memory pool (pointer start 0x20, limit 0xA0 exclusive); type[5]=0 SHALL allocate from the I/O pool (pointer start 0xE9, limit 0xF0 exclusive).
REQ-020 Base SHALL be the pool pointer rounded up to a multiple of size, except size 128, which SHALL be placed only at 0x20 and only while the memory pointer is 0x20.
REQ-021 Arithmetic SHALL be 9-bit; the board fits when base+size<=limit; on fit the pointer SHALL become base+size.
REQ-022 On fit: WR_LO SHALL write base[3:0] to 0x4A, then WR_HI SHALL write base[7:4] to 0x48 (commit); on no fit: SHUTUP SHALL write 0x0 to 0x4C.
REQ-023 NEXT SHALL pulse CFG_STB with CFG_BASE (0x00 when shut up) and CFG_SHUT, increment NBOARDS, and return to RD_HI; after 8 boards it SHALL go to FINISH.
REQ-024 FINISH SHALL set DONE=1, clear BUSY and go to IDLE; DONE SHALL hold until the next accepted START, which SHALL clear DONE, ERR and NBOARDS and reset both pool pointers.
REQ-025 BUSY SHALL be 1 in every state except IDLE.

Reset
REQ-026 RESET=1 SHALL immediately force IDLE and drive ZREQ, ZRW, ZOFS, ZWDATA, BUSY, DONE, ERR, NBOARDS, CFG_STB, CFG_BASE and CFG_SHUT to 0, and the pools to 0x20 and 0xE9.
REQ-027 Reset mid-transaction SHALL drop ZREQ in the same instant, and no write SHALL be reissued after release.

Configuration
REQ-028 With AC_TIMEOUT_EN defined, an 8-bit counter SHALL abort any request that gets no ZACK within 255 cycles: ZREQ low, ERR=1, go to FINISH.
REQ-029 Without AC_TIMEOUT_EN, the block SHALL wait indefinitely for ZACK, and ERR SHALL be constant 0.

Verification
REQ-030 Type 0xE5 (memory, 1MB), START -> writes 0x0@0x4A then 0x2@0x48; CFG_BASE=0x20, CFG_SHUT=0.
REQ-031 Types 0xE1 (64K mem), then 0xE6 (2MB mem), then 0xFF... type read 0x0F -> bases 0x20, 0x40; NBOARDS=2; DONE=1.
REQ-032 Type 0xC1 (I/O, 64K) x8 -> bases 0xE9..0xEF for 7 boards, eighth SHUTUP at 0x4C; NBOARDS=8, FINISH.
REQ-033 Type 0xE0 (8MB) after a 64K board -> SHUTUP, CFG_SHUT=1, CFG_BASE=0x00.
REQ-034 With AC_TIMEOUT_EN, ZACK withheld on RD_HI -> ZREQ drops after 255 cycles, ERR=1, DONE=1, NBOARDS=0.
REQ-035 RESET asserted during WR_HI with ZREQ high -> ZREQ=0 asynchronously, all outputs 0, no further request until START.
